// File: rtl/shift_unit_serial_if.sv
// Handshake and data bundle between the control unit and the serial shifter.
// master = control unit, slave = shift_unit_serial.
interface shift_unit_serial_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   din;
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output op,
    output shamt,
    output din,
    input  result,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  op,
    input  shamt,
    input  din,
    output result,
    output busy,
    output done
  );
endinterface

// File: rtl/shift_unit_serial.sv
// Serial shift/rotate unit: one bit position per clock, result feeds the
// ALU B-operand mux (RegDeslocamento input).
module shift_unit_serial #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic                clk,
  input logic                reset,
  shift_unit_serial_if.slave bus
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               op_ok;

  assign op_ok = (bus.op <= OP_ROL);

  always_comb begin
    step = res_q;
    unique case (1'b1)
      op_q == OP_SLL: step = {res_q[WIDTH-2:0], 1'b0};
      op_q == OP_SRL: step = {1'b0, res_q[WIDTH-1:1]};
      op_q == OP_SRA: step = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
      op_q == OP_ROR: step = {res_q[0], res_q[WIDTH-1:1]};
      op_q == OP_ROL: step = {res_q[WIDTH-2:0], res_q[WIDTH-1]};
      default:        step = res_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          res_d = bus.din;
          op_d  = bus.op;
          cnt_d = bus.shamt;
          // Invalid op or zero amount skips straight to DONE (pass-through).
          if (bus.shamt != '0 && op_ok) state_d = S_SHIFT;
          else                          state_d = S_DONE;
        end
      end
      S_SHIFT: begin
        res_d = step;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.result = res_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_unit_serial.sv
// Bench for shift_unit_serial: timing/result model plus directed
// vectors with hand-computed literal expectations.
module tb_shift_unit_serial;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  shift_unit_serial_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_unit_serial #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(
    input logic [2:0] op, input logic [4:0] s, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      3'd0: r = d << s;
      3'd1: r = d >> s;
      3'd2: r = $signed(d) >>> s;
      3'd3: r = (d >> s) | (d << (32 - int'(s)));
      3'd4: r = (d << s) | (d >> (32 - int'(s)));
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int ref_steps(input logic [2:0] op, input logic [4:0] s);
    return (op <= 3'd4) ? int'(s) : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: an accepted op occupies periods t+1 .. t+1+steps, done in the last.
  bit          m_active  = 1'b0;
  int          m_done_at = 0;
  logic [31:0] m_res     = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_active <= 1'b0;
      m_res    <= '0;
    end else if (bus.start && !(m_active && cyc <= m_done_at)) begin
      m_active  <= 1'b1;
      m_done_at <= cyc + 1 + ref_steps(bus.op, bus.shamt);
      m_res     <= ref_shift(bus.op, bus.shamt, bus.din);
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      automatic bit eb = m_active && (cyc <= m_done_at);
      automatic bit ed = m_active && (cyc == m_done_at);
      chk("busy", 32'(bus.busy), 32'(eb));
      chk("done", 32'(bus.done), 32'(ed));
      if (!eb || ed) chk("result", bus.result, m_res);
    end
  end

  task automatic wait_done(input int t0, output int lat, output bit seen);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        lat  = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run(input string nm, input logic [2:0] op,
                     input logic [4:0] s, input logic [31:0] d,
                     input logic [31:0] er, input int el);
    int t0, lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.shamt = s;
    bus.din   = d;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(t0, lat, seen);
    chk({nm, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "_lat"}, 32'(lat), 32'(el));
      chk({nm, "_res"}, bus.result, er);
    end
    @(negedge clk);
  endtask

  initial begin
    int t0, lat;
    bit seen;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.shamt = '0;
    bus.din   = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    run("sll4", 3'd0, 5'd4, 32'h0000_0001, 32'h0000_0010, 5);
    run("sra31", 3'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32);
    run("srl31", 3'd1, 5'd31, 32'h8000_0000, 32'h0000_0001, 32);
    run("ror1", 3'd3, 5'd1, 32'h0000_0001, 32'h8000_0000, 2);
    run("rol4", 3'd4, 5'd4, 32'h8000_0001, 32'h0000_0018, 5);
    run("sll0", 3'd0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    run("badop", 3'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, 1);
    run("sra4", 3'd2, 5'd4, 32'h8765_4321, 32'hF876_5432, 5);

    // Start while busy is ignored; late input changes have no effect.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.shamt = 5'd3; bus.din = 32'h1;
    t0 = cyc;
    @(negedge clk);
    bus.op = 3'd1; bus.shamt = 5'd1; bus.din = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd3; bus.din = 32'hA5A5_A5A5;
    wait_done(t0, lat, seen);
    chk("ign_seen", 32'(seen), 32'd1);
    chk("ign_lat", 32'(lat), 32'd4);
    chk("ign_res", bus.result, 32'h0000_0008);
    @(negedge clk);

    // Reset mid-shift aborts with no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.shamt = 5'd10; bus.din = 32'h1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_res", bus.result, 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_nodone", 32'(bus.done), 32'd0);
    end
    run("after_rst", 3'd1, 5'd4, 32'h0000_00F0, 32'h0000_000F, 5);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
